// File: rtl/qtable_pkg.sv
// qtable_pkg: shared packet types, FSM states and Q2.14 widths for the Q-table engine
package qtable_pkg;
   localparam int Q_INT = 2;
   localparam int Q_FRAC = 14;
   localparam int Q_WIDTH = Q_INT + Q_FRAC;
   localparam logic [2:0] PKT_NONE = 3'b000;
   localparam logic [2:0] PKT_HELLO = 3'b001;
   localparam logic [2:0] PKT_CH_ADV = 3'b010;
   localparam logic [2:0] PKT_JOIN = 3'b011;
   localparam logic [2:0] PKT_ROUTE = 3'b100;
   localparam logic [2:0] PKT_DATA = 3'b101;
   localparam logic [2:0] PKT_ACK = 3'b110;
   localparam logic [2:0] PKT_CTRL = 3'b111;
   typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_NWRITE, S_CHSEARCH, S_CHWRITE, S_DONE} state_e;
endpackage

// File: rtl/qtable_update_param_if.sv
// qtable_update_param_if: packet request in, busy/done/dropped status out
interface qtable_update_param_if #(parameter int WW = 16);
   logic en;
   logic [WW-1:0] fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue;
   logic [2:0] fPacketType;
   logic busy, done, dropped;
   modport master (output en, fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fPacketType,
                   input busy, done, dropped);
   modport slave (input en, fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fPacketType,
                  output busy, done, dropped);
endinterface

// File: rtl/id_table_scan.sv
// id_table_scan: one-entry-per-cycle ID search tracking match, min-Q and max-Q (matches excluded)
module id_table_scan #(
   parameter int W = 16,
   parameter int IW = 4
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          clr,
   input  logic          vld,
   input  logic [W-1:0]  key,
   input  logic [W-1:0]  ent_id,
   input  logic [W-1:0]  ent_q,
   input  logic [IW-1:0] idx,
   output logic          hit,
   output logic [IW-1:0] hit_idx,
   output logic [IW-1:0] min_idx,
   output logic [W-1:0]  min_q,
   output logic          max_vld,
   output logic [IW-1:0] max_idx,
   output logic [W-1:0]  max_id,
   output logic [W-1:0]  max_q
);
   logic hit_q, hit_d, min_vld_q, min_vld_d, max_vld_q, max_vld_d;
   logic [IW-1:0] hit_idx_q, hit_idx_d, min_idx_q, min_idx_d, max_idx_q, max_idx_d;
   logic [W-1:0] min_q_q, min_q_d, max_id_q, max_id_d, max_q_q, max_q_d;
   logic is_hit, take_min, take_max;
   always_comb begin
      is_hit = vld && ent_id == key;
      take_min = vld && (!min_vld_q || ent_q < min_q_q);
      // the matched entry is about to be rewritten, so it must not hold the running max
      take_max = vld && !is_hit && (!max_vld_q || ent_q > max_q_q);
      hit_d = !clr && (hit_q || is_hit);
      hit_idx_d = is_hit ? idx : hit_idx_q;
      min_vld_d = !clr && (min_vld_q || vld);
      min_idx_d = take_min ? idx : min_idx_q;
      min_q_d = take_min ? ent_q : min_q_q;
      max_vld_d = !clr && (max_vld_q || take_max);
      max_idx_d = take_max ? idx : max_idx_q;
      max_id_d = take_max ? ent_id : max_id_q;
      max_q_d = take_max ? ent_q : max_q_q;
   end
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         hit_q <= 1'b0;
         min_vld_q <= 1'b0;
         max_vld_q <= 1'b0;
         hit_idx_q <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
         min_q_q <= '0;
         max_id_q <= '0;
         max_q_q <= '0;
      end else begin
         hit_q <= hit_d;
         min_vld_q <= min_vld_d;
         max_vld_q <= max_vld_d;
         hit_idx_q <= hit_idx_d;
         min_idx_q <= min_idx_d;
         max_idx_q <= max_idx_d;
         min_q_q <= min_q_d;
         max_id_q <= max_id_d;
         max_q_q <= max_q_d;
      end
   end
   assign hit = hit_q;
   assign hit_idx = hit_idx_q;
   assign min_idx = min_idx_q;
   assign min_q = min_q_q;
   assign max_vld = max_vld_q;
   assign max_idx = max_idx_q;
   assign max_id = max_id_q;
   assign max_q = max_q_q;
endmodule

// File: rtl/qtable_update_param.sv
// qtable_update_param: neighbour Q-table and known-CH list update engine with best next hop
module qtable_update_param import qtable_pkg::*; #(
   parameter int WORD_WIDTH = Q_WIDTH,
   parameter int NBR_DEPTH = 16,
   parameter int CH_DEPTH = 8,
   parameter logic [7:0] UPD_MASK = 8'b0011_1110,
   localparam int WW = WORD_WIDTH,
   localparam int NW = $clog2(NBR_DEPTH)
) (
   input  logic clk,
   input  logic nrst,
   qtable_update_param_if.slave bus,
   input  logic [NW-1:0] rd_idx,
   output logic [WW-1:0] rd_id,
   output logic [WW-1:0] rd_hops,
   output logic [WW-1:0] rd_cid,
   output logic [WW-1:0] rd_energy,
   output logic [WW-1:0] rd_q,
   output logic [WW-1:0] neighborCount,
   output logic [WW-1:0] knownCHCount,
   output logic [WW-1:0] bestID,
   output logic [WW-1:0] bestQ
);
   localparam int CW = (CH_DEPTH > 1) ? $clog2(CH_DEPTH) : 1;
   localparam int SW = (NW > CW) ? NW : CW;
   localparam int CNTW = SW + 1;
   localparam int EW = 5 * WW;
   typedef logic [EW-1:0] ent_t;
   state_e state_q, state_d;
   logic [SW-1:0] idx_q, idx_d;
   ent_t req_q, req_d, rd_ent;
   ent_t tbl_q [NBR_DEPTH];
   ent_t tbl_d [NBR_DEPTH];
   logic [WW-1:0] ch_q [CH_DEPTH];
   logic [WW-1:0] ch_d [CH_DEPTH];
   logic [CNTW-1:0] nc_q, nc_d, cc_q, cc_d, idx_nx;
   logic drop_q, drop_d;
   logic [WW-1:0] best_id_q, best_id_d, best_q_q, best_q_d, r_id, r_cid, r_q;
   logic n_hit, n_max_vld, ch_hit, full, nbr_we, new_best;
   logic [NW-1:0] n_hit_idx, n_min_idx, n_max_idx, wr_idx;
   logic [WW-1:0] n_min_q, n_max_id, n_max_q;
   logic [CW-1:0] ch_unused_hit_idx, ch_unused_min_idx, ch_unused_max_idx;
   logic [WW-1:0] ch_unused_min_q, ch_unused_max_id, ch_unused_max_q;
   logic ch_unused_max_vld;
   assign r_id = req_q[EW-1 -: WW];
   assign r_cid = req_q[3*WW-1 -: WW];
   assign r_q = req_q[WW-1:0];
   assign idx_nx = {1'b0, idx_q} + CNTW'(1);
   id_table_scan #(.W(WW), .IW(NW)) u_nbr_scan (
      .clk(clk), .nrst(nrst), .clr(state_q == S_IDLE),
      .vld(state_q == S_SEARCH && {1'b0, idx_q} < nc_q),
      .key(r_id), .ent_id(tbl_q[idx_q[NW-1:0]][EW-1 -: WW]), .ent_q(tbl_q[idx_q[NW-1:0]][WW-1:0]),
      .idx(idx_q[NW-1:0]), .hit(n_hit), .hit_idx(n_hit_idx), .min_idx(n_min_idx), .min_q(n_min_q),
      .max_vld(n_max_vld), .max_idx(n_max_idx), .max_id(n_max_id), .max_q(n_max_q)
   );
   id_table_scan #(.W(WW), .IW(CW)) u_ch_scan (
      .clk(clk), .nrst(nrst), .clr(state_q == S_NWRITE),
      .vld(state_q == S_CHSEARCH && {1'b0, idx_q} < cc_q),
      .key(r_id), .ent_id(ch_q[idx_q[CW-1:0]]), .ent_q('0), .idx(idx_q[CW-1:0]),
      .hit(ch_hit), .hit_idx(ch_unused_hit_idx), .min_idx(ch_unused_min_idx), .min_q(ch_unused_min_q),
      .max_vld(ch_unused_max_vld), .max_idx(ch_unused_max_idx), .max_id(ch_unused_max_id),
      .max_q(ch_unused_max_q)
   );
   assign full = nc_q == CNTW'(NBR_DEPTH);
   assign wr_idx = n_hit ? n_hit_idx : full ? n_min_idx : nc_q[NW-1:0];
   assign nbr_we = state_q == S_NWRITE && (n_hit || !full || r_q > n_min_q);
   // a replaced min entry can only have been the scan max if all Q were equal, so the new entry wins anyway
   assign new_best = !n_max_vld || r_q > n_max_q || (r_q == n_max_q && wr_idx < n_max_idx);
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      req_d = req_q;
      tbl_d = tbl_q;
      ch_d = ch_q;
      nc_d = nc_q;
      cc_d = cc_q;
      drop_d = drop_q;
      best_id_d = best_id_q;
      best_q_d = best_q_q;
      case (state_q)
         S_IDLE: if (bus.en) begin
            req_d = {bus.fSourceID, bus.fSourceHops, bus.fClusterID, bus.fEnergyLeft, bus.fQValue};
            idx_d = '0;
            drop_d = 1'b0;
            state_d = UPD_MASK[bus.fPacketType] ? S_SEARCH : S_DONE;
         end
         S_SEARCH: begin
            idx_d = idx_nx >= nc_q ? '0 : idx_nx[SW-1:0];
            state_d = idx_nx >= nc_q ? S_NWRITE : S_SEARCH;
         end
         S_NWRITE: begin
            if (nbr_we) tbl_d[wr_idx] = req_q;
            best_id_d = nbr_we && new_best ? r_id : nbr_we ? n_max_id : best_id_q;
            best_q_d = nbr_we && new_best ? r_q : nbr_we ? n_max_q : best_q_q;
            nc_d = !n_hit && !full ? nc_q + CNTW'(1) : nc_q;
            drop_d = !nbr_we;
            state_d = r_cid == r_id ? S_CHSEARCH : S_DONE;
         end
         S_CHSEARCH: begin
            idx_d = idx_nx >= cc_q ? '0 : idx_nx[SW-1:0];
            state_d = idx_nx >= cc_q ? S_CHWRITE : S_CHSEARCH;
         end
         S_CHWRITE: begin
            if (!ch_hit && cc_q < CNTW'(CH_DEPTH)) begin
               ch_d[cc_q[CW-1:0]] = r_id;
               cc_d = cc_q + CNTW'(1);
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         idx_q <= '0;
         req_q <= '0;
         nc_q <= '0;
         cc_q <= '0;
         drop_q <= 1'b0;
         best_id_q <= '0;
         best_q_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         req_q <= req_d;
         nc_q <= nc_d;
         cc_q <= cc_d;
         drop_q <= drop_d;
         best_id_q <= best_id_d;
         best_q_q <= best_q_d;
      end
   end
   always_ff @(posedge clk) begin
      tbl_q <= tbl_d;
      ch_q <= ch_d;
   end
   assign rd_ent = CNTW'(rd_idx) < nc_q ? tbl_q[rd_idx] : '0;
   assign {rd_id, rd_hops, rd_cid, rd_energy, rd_q} = rd_ent;
   assign neighborCount = WW'(nc_q);
   assign knownCHCount = WW'(cc_q);
   assign bestID = best_id_q;
   assign bestQ = best_q_q;
   assign bus.busy = state_q != S_IDLE;
   assign bus.done = state_q == S_DONE;
   assign bus.dropped = state_q == S_DONE && drop_q;
endmodule

// File: tb/tb_qtable_update_param.sv
// tb_qtable_update_param: directed and random requests checked against a table-level reference model
module tb_qtable_update_param;
   import qtable_pkg::*;
   localparam int WW = 16;
   localparam int ND = 16;
   localparam int CD = 8;
   localparam logic [7:0] MASK = 8'b0011_1110;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic [3:0] rd_idx = '0;
   logic [WW-1:0] rd_id, rd_hops, rd_cid, rd_energy, rd_q, neighborCount, knownCHCount, bestID, bestQ;
   int checks = 0;
   int failures = 0;
   int last_lat;
   bit last_drop;
   logic [WW-1:0] m_id [ND];
   logic [WW-1:0] m_hops [ND];
   logic [WW-1:0] m_cid [ND];
   logic [WW-1:0] m_en [ND];
   logic [WW-1:0] m_q [ND];
   logic [WW-1:0] m_ch [CD];
   int m_n = 0;
   int m_c = 0;
   always #5 clk = ~clk;
   qtable_update_param_if #(.WW(WW)) bus ();
   qtable_update_param #(.WORD_WIDTH(WW), .NBR_DEPTH(ND), .CH_DEPTH(CD), .UPD_MASK(MASK)) dut (
      .clk(clk), .nrst(nrst), .bus(bus), .rd_idx(rd_idx), .rd_id(rd_id), .rd_hops(rd_hops),
      .rd_cid(rd_cid), .rd_energy(rd_energy), .rd_q(rd_q), .neighborCount(neighborCount),
      .knownCHCount(knownCHCount), .bestID(bestID), .bestQ(bestQ)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic model_req(input logic [WW-1:0] id, hops, cid, e, q, input logic [2:0] t,
                            output int lat, output bit drop);
      int hit = -1;
      int slot = -1;
      int mn = 0;
      bit known = 0;
      drop = 0;
      lat = 1;
      if (MASK[t]) begin
         lat = (m_n == 0 ? 1 : m_n) + 2;
         for (int i = 0; i < m_n; i++) if (m_id[i] == id) hit = i;
         if (hit >= 0) slot = hit;
         else if (m_n < ND) begin
            slot = m_n;
            m_n++;
         end else begin
            for (int i = 1; i < ND; i++) if (m_q[i] < m_q[mn]) mn = i;
            slot = q > m_q[mn] ? mn : -1;
         end
         if (slot < 0) drop = 1;
         else begin
            m_id[slot] = id; m_hops[slot] = hops; m_cid[slot] = cid; m_en[slot] = e; m_q[slot] = q;
         end
         if (cid == id) begin
            lat += (m_c == 0 ? 1 : m_c) + 1;
            for (int i = 0; i < m_c; i++) if (m_ch[i] == id) known = 1;
            if (!known && m_c < CD) begin
               m_ch[m_c] = id;
               m_c++;
            end
         end
      end
   endtask
   task automatic verify(input string tag);
      int b = 0;
      for (int i = 1; i < m_n; i++) if (m_q[i] > m_q[b]) b = i;
      check({tag, " ncount"}, neighborCount, m_n);
      check({tag, " chcount"}, knownCHCount, m_c);
      check({tag, " best_id"}, bestID, m_n == 0 ? 0 : m_id[b]);
      check({tag, " best_q"}, bestQ, m_n == 0 ? 0 : m_q[b]);
      for (int i = 0; i < ND; i++) begin
         rd_idx = 4'(i);
         #1;
         check($sformatf("%s rd%0d id", tag, i), rd_id, i < m_n ? m_id[i] : 0);
         check($sformatf("%s rd%0d hops", tag, i), rd_hops, i < m_n ? m_hops[i] : 0);
         check($sformatf("%s rd%0d cid", tag, i), rd_cid, i < m_n ? m_cid[i] : 0);
         check($sformatf("%s rd%0d energy", tag, i), rd_energy, i < m_n ? m_en[i] : 0);
         check($sformatf("%s rd%0d q", tag, i), rd_q, i < m_n ? m_q[i] : 0);
      end
      rd_idx = '0;
   endtask
   task automatic send(input string tag, input logic [WW-1:0] id, hops, cid, e, q, input logic [2:0] t);
      int exp_lat;
      bit exp_drop;
      model_req(id, hops, cid, e, q, t, exp_lat, exp_drop);
      @(negedge clk);
      bus.en = 1'b1;
      bus.fSourceID = id; bus.fSourceHops = hops; bus.fClusterID = cid;
      bus.fEnergyLeft = e; bus.fQValue = q; bus.fPacketType = t;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      bus.fSourceID = 16'($urandom); bus.fSourceHops = 16'($urandom); bus.fClusterID = 16'($urandom);
      bus.fEnergyLeft = 16'($urandom); bus.fQValue = 16'($urandom); bus.fPacketType = PKT_DATA;
      check({tag, " busy"}, bus.busy, 1);
      last_lat = 1;
      if (!bus.done) bus.en = 1'b1;
      while (!bus.done && last_lat < 200) begin
         @(posedge clk);
         #1;
         bus.en = 1'b0;
         last_lat++;
      end
      last_drop = bus.dropped;
      check({tag, " latency"}, last_lat, exp_lat);
      check({tag, " dropped"}, last_drop, exp_drop);
      @(posedge clk);
      #1;
      check({tag, " idle"}, bus.busy, 0);
      check({tag, " done_pulse"}, bus.done, 0);
      verify(tag);
   endtask
   task automatic do_reset(input string tag);
      nrst = 1'b0;
      @(negedge clk);
      bus.en = 1'b1;
      bus.fPacketType = PKT_DATA;
      m_n = 0;
      m_c = 0;
      repeat (2) @(posedge clk);
      #1;
      check({tag, " busy"}, bus.busy, 0);
      check({tag, " done"}, bus.done, 0);
      check({tag, " dropped"}, bus.dropped, 0);
      verify(tag);
      @(negedge clk);
      bus.en = 1'b0;
      nrst = 1'b1;
   endtask
   initial begin
      bus.en = 1'b0;
      bus.fSourceID = '0; bus.fSourceHops = '0; bus.fClusterID = '0;
      bus.fEnergyLeft = '0; bus.fQValue = '0; bus.fPacketType = '0;
      do_reset("rst0");
      send("t1", 16'd1, 16'd3, 16'd2, 16'h8000, 16'h3000, PKT_DATA);
      check("t1 lat3", last_lat, 3);
      check("t1 count", neighborCount, 1);
      check("t1 best_id", bestID, 1);
      check("t1 best_q", bestQ, 16'h3000);
      send("t2", 16'd1, 16'd3, 16'd3, 16'h8000, 16'hB800, PKT_DATA);
      rd_idx = '0;
      #1;
      check("t2 count", neighborCount, 1);
      check("t2 rd_q", rd_q, 16'hB800);
      check("t2 rd_cid", rd_cid, 3);
      check("t2 best_q", bestQ, 16'hB800);
      do_reset("rst1");
      for (int i = 0; i < ND; i++) send("t3fill", 16'(100 + i), 16'd1, 16'd50, 16'h4000, 16'(16'h1000 + i), PKT_DATA);
      send("t3drop", 16'd200, 16'd1, 16'd50, 16'h4000, 16'h0800, PKT_DATA);
      check("t3 drop", last_drop, 1);
      check("t3 count", neighborCount, ND);
      send("t3repl", 16'd201, 16'd1, 16'd50, 16'h4000, 16'h3F00, PKT_DATA);
      rd_idx = '0;
      #1;
      check("t3 repl id", rd_id, 201);
      check("t3 best", bestID, 201);
      send("t4", 16'd201, 16'd1, 16'd50, 16'h4000, 16'h0100, PKT_DATA);
      check("t4 best_id", bestID, 115);
      check("t4 best_q", bestQ, 16'h100F);
      do_reset("rst2");
      send("t5a", 16'd7, 16'd1, 16'd7, 16'h2000, 16'h2000, PKT_DATA);
      send("t5b", 16'd7, 16'd1, 16'd7, 16'h2000, 16'h2100, PKT_DATA);
      check("t5 chcount1", knownCHCount, 1);
      for (int i = 20; i < 28; i++) send("t5ch", 16'(i), 16'd1, 16'(i), 16'h2000, 16'(i), PKT_DATA);
      check("t5 chsat", knownCHCount, CD);
      send("t6mask", 16'd50, 16'd1, 16'd50, 16'h2000, 16'hFFFF, 3'b000);
      check("t6 lat1", last_lat, 1);
      @(negedge clk);
      bus.en = 1'b1; bus.fSourceID = 16'd60; bus.fClusterID = 16'd60; bus.fQValue = 16'h7000;
      bus.fPacketType = PKT_DATA;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      @(posedge clk);
      #2;
      nrst = 1'b0;
      m_n = 0;
      m_c = 0;
      #1;
      check("t6 rst busy", bus.busy, 0);
      verify("t6rst");
      @(negedge clk);
      nrst = 1'b1;
      send("t6after", 16'd61, 16'd2, 16'd61, 16'h1234, 16'h2345, PKT_HELLO);
      do_reset("rst3");
      for (int n = 0; n < 200; n++) begin
         logic [WW-1:0] id, q;
         logic [2:0] t;
         id = 16'($urandom_range(1, 24));
         q = ($urandom % 3 == 0) ? {2'($urandom_range(1, 3)), 14'h0} : 16'($urandom);
         t = ($urandom % 5 == 0) ? 3'($urandom) : 3'($urandom_range(1, 5));
         send("rnd", id, 16'($urandom), ($urandom % 3 == 0) ? id : 16'($urandom_range(1, 30)),
              16'($urandom), q, t);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
